// File: rtl/hid2ps2.sv
// HID boot-keyboard report to PS/2 Set 2 scancode translator.
// Diffs each new report against the last translated one and streams make/break bytes.
module hid2ps2 #(
    parameter bit IGNORE_ROLLOVER = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [63:0] usb_kb_hid,
    output logic [7:0]  ps2_data,
    output logic        ps2_valid,
    input  logic        ps2_ready,
    output logic        busy
);

    typedef enum logic [2:0] {IDLE, SCAN, EMIT_E0, EMIT_F0, EMIT_CODE} state_t;

    localparam logic [4:0] LAST_CAND = 5'd27;

    // {E0 prefix, code}; all-zero means the usage has no Set 2 code
    function automatic logic [8:0] key_map(input logic [7:0] u);
        logic [8:0] r;
        case (u)
            8'h04: r = 9'h01C;  8'h05: r = 9'h032;  8'h06: r = 9'h021;  8'h07: r = 9'h023;
            8'h08: r = 9'h024;  8'h09: r = 9'h02B;  8'h0A: r = 9'h034;  8'h0B: r = 9'h033;
            8'h0C: r = 9'h043;  8'h0D: r = 9'h03B;  8'h0E: r = 9'h042;  8'h0F: r = 9'h04B;
            8'h10: r = 9'h03A;  8'h11: r = 9'h031;  8'h12: r = 9'h044;  8'h13: r = 9'h04D;
            8'h14: r = 9'h015;  8'h15: r = 9'h02D;  8'h16: r = 9'h01B;  8'h17: r = 9'h02C;
            8'h18: r = 9'h03C;  8'h19: r = 9'h02A;  8'h1A: r = 9'h01D;  8'h1B: r = 9'h022;
            8'h1C: r = 9'h035;  8'h1D: r = 9'h01A;  8'h1E: r = 9'h016;  8'h1F: r = 9'h01E;
            8'h20: r = 9'h026;  8'h21: r = 9'h025;  8'h22: r = 9'h02E;  8'h23: r = 9'h036;
            8'h24: r = 9'h03D;  8'h25: r = 9'h03E;  8'h26: r = 9'h046;  8'h27: r = 9'h045;
            8'h28: r = 9'h05A;  8'h29: r = 9'h076;  8'h2A: r = 9'h066;  8'h2B: r = 9'h00D;
            8'h2C: r = 9'h029;  8'h2D: r = 9'h04E;  8'h2E: r = 9'h055;  8'h2F: r = 9'h054;
            8'h30: r = 9'h05B;  8'h31: r = 9'h05D;  8'h32: r = 9'h05D;  8'h33: r = 9'h04C;
            8'h34: r = 9'h052;  8'h35: r = 9'h00E;  8'h36: r = 9'h041;  8'h37: r = 9'h049;
            8'h38: r = 9'h04A;  8'h39: r = 9'h058;  8'h3A: r = 9'h005;  8'h3B: r = 9'h006;
            8'h3C: r = 9'h004;  8'h3D: r = 9'h00C;  8'h3E: r = 9'h003;  8'h3F: r = 9'h00B;
            8'h40: r = 9'h083;  8'h41: r = 9'h00A;  8'h42: r = 9'h001;  8'h43: r = 9'h009;
            8'h44: r = 9'h078;  8'h45: r = 9'h007;  8'h47: r = 9'h07E;  8'h49: r = 9'h170;
            8'h4A: r = 9'h16C;  8'h4B: r = 9'h17D;  8'h4C: r = 9'h171;  8'h4D: r = 9'h169;
            8'h4E: r = 9'h17A;  8'h4F: r = 9'h174;  8'h50: r = 9'h16B;  8'h51: r = 9'h172;
            8'h52: r = 9'h175;  8'h53: r = 9'h077;  8'h54: r = 9'h14A;  8'h55: r = 9'h07C;
            8'h56: r = 9'h07B;  8'h57: r = 9'h079;  8'h58: r = 9'h15A;  8'h59: r = 9'h069;
            8'h5A: r = 9'h072;  8'h5B: r = 9'h07A;  8'h5C: r = 9'h06B;  8'h5D: r = 9'h073;
            8'h5E: r = 9'h074;  8'h5F: r = 9'h06C;  8'h60: r = 9'h075;  8'h61: r = 9'h07D;
            8'h62: r = 9'h070;  8'h63: r = 9'h071;  8'h64: r = 9'h061;  8'h65: r = 9'h12F;
            default: r = 9'h000;
        endcase
        return r;
    endfunction

    function automatic logic [8:0] mod_map(input logic [2:0] b);
        logic [8:0] r;
        case (b)
            3'd0: r = 9'h014;  3'd1: r = 9'h012;  3'd2: r = 9'h011;  3'd3: r = 9'h11F;
            3'd4: r = 9'h114;  3'd5: r = 9'h059;  3'd6: r = 9'h111;  default: r = 9'h127;
        endcase
        return r;
    endfunction

    state_t      state, nstate;
    logic [63:0] prev, cur;
    logic [4:0]  idx;
    logic        ev_brk;
    logic [7:0]  ev_code;

    logic [5:0][7:0] hid_s;
    logic            rollover, start;

    logic            cand_brk, cand_hit, dup, in_oth;
    logic [4:0]      rel;
    logic [2:0]      slot, sidx;
    logic [63:0]     self_r, oth_r;
    logic [7:0]      self_m, oth_m, key;
    logic [5:0][7:0] self_s, oth_s;
    logic [8:0]      cand_code;
    logic            scan_step, last;

    logic unused_rsvd;
    assign unused_rsvd = ^prev[55:48];

    always_comb begin
        hid_s    = usb_kb_hid[47:0];
        rollover = 1'b0;
        for (int p = 0; p < 6; p++)
            if (hid_s[p] == 8'h01) rollover = 1'b1;
        start = ({usb_kb_hid[63:56], usb_kb_hid[47:0]} != {prev[63:56], prev[47:0]})
                && !(IGNORE_ROLLOVER && rollover);
    end

    // Candidates 0..13 are breaks (self=prev, other=cur), 14..27 makes (roles swapped).
    always_comb begin
        cand_brk = idx < 5'd14;
        rel      = cand_brk ? idx : idx - 5'd14;
        slot     = 3'(rel - 5'd8);
        sidx     = 3'd5 - slot;
        self_r   = cand_brk ? prev : cur;
        oth_r    = cand_brk ? cur : prev;
        self_m   = self_r[63:56];
        oth_m    = oth_r[63:56];
        self_s   = self_r[47:0];
        oth_s    = oth_r[47:0];
        key      = self_s[sidx];
        dup      = 1'b0;
        in_oth   = 1'b0;
        // sc1 sits at the top byte, so an earlier slot has a higher packed index
        for (int p = 0; p < 6; p++) begin
            if (p > int'(sidx) && self_s[p] == key) dup = 1'b1;
            if (oth_s[p] == key) in_oth = 1'b1;
        end
        if (rel < 5'd8) begin
            cand_code = mod_map(rel[2:0]);
            cand_hit  = self_m[rel[2:0]] & ~oth_m[rel[2:0]];
        end else begin
            cand_code = key_map(key);
            cand_hit  = (cand_code != 9'h000) && !dup && !in_oth;
        end
    end

    assign last      = idx == LAST_CAND;
    assign scan_step = (state == SCAN && !cand_hit) || (state == EMIT_CODE && ps2_ready);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= nstate;
    end

    always_comb begin
        nstate = state;
        case (state)
            IDLE:      if (start) nstate = SCAN;
            SCAN: begin
                if (cand_hit)  nstate = cand_code[8] ? EMIT_E0 : (cand_brk ? EMIT_F0 : EMIT_CODE);
                else if (last) nstate = IDLE;
            end
            EMIT_E0:   if (ps2_ready) nstate = ev_brk ? EMIT_F0 : EMIT_CODE;
            EMIT_F0:   if (ps2_ready) nstate = EMIT_CODE;
            EMIT_CODE: if (ps2_ready) nstate = last ? IDLE : SCAN;
            default:   nstate = IDLE;
        endcase
    end

    always_comb begin
        ps2_valid = 1'b0;
        ps2_data  = 8'h00;
        busy      = state != IDLE;
        case (state)
            EMIT_E0:   begin ps2_valid = 1'b1; ps2_data = 8'hE0;    end
            EMIT_F0:   begin ps2_valid = 1'b1; ps2_data = 8'hF0;    end
            EMIT_CODE: begin ps2_valid = 1'b1; ps2_data = ev_code; end
            default:   ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prev    <= '0;
            cur     <= '0;
            idx     <= '0;
            ev_brk  <= 1'b0;
            ev_code <= 8'h00;
        end else begin
            if (state == IDLE && start) begin
                cur <= usb_kb_hid;
                idx <= '0;
            end
            if (state == SCAN && cand_hit) begin
                ev_brk  <= cand_brk;
                ev_code <= cand_code[7:0];
            end
            if (scan_step) begin
                if (last) prev <= cur;
                else      idx  <= idx + 5'd1;
            end
        end
    end

endmodule
